life_keypad: RTL and testbench
==============================

Name: life_keypad

Overview:
- Front-end control stage that directly feeds the life core's `keys`, `cursor_x` and `cursor_y` inputs.
- Synchronises and debounces the raw board push-buttons.
- Maintains the edit cursor with wrap-around and auto-repeat.
- Issues one-cycle key command codes to the core, gated by a core-ready handshake.

Parameters:
- X, 8, board width in cells.
- Y, 8, board height in cells.
- LOG2X, 3, cursor_x width; X <= 2^LOG2X.
- LOG2Y, 3, cursor_y width; Y <= 2^LOG2Y.
- DEBOUNCE_BITS, 16, debounce counter width; stable after 2^DEBOUNCE_BITS equal samples.
- REPEAT_DELAY, 24'd6000000, cycles a cursor button is held before auto-repeat starts.
- REPEAT_RATE, 24'd1500000, cycles between auto-repeat moves.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_up / btn_down / btn_left / btn_right  in  1 each  raw asynchronous buttons, active-high
- btn_set  in  1  raw button: toggle cell under cursor
- btn_step  in  1  raw button: advance one generation
- ready  in  1  core accepts a command this cycle
- keys  out  3  command code; valid for exactly one cycle
- cursor_x  out  LOG2X  cursor column
- cursor_y  out  LOG2Y  cursor row
- cmd_pending  out  1  a command is waiting for ready

Behaviour:
- Reset: keys=0, cursor_x=0, cursor_y=0, cmd_pending=0. Clears all sync flops, debounce counters, stable states and repeat timers.
- Command codes (normative, shared key_codes.vh): NONE=0, TOGGLE=1, STEP=2, CLEAR=3. Codes 4-7 are never driven.
- Synchronisation: every raw button passes through a 2-flop synchroniser.
- Debounce, per button:
  - Counter increments while the synced value differs from the stable value; it resets to 0 when they match.
  - When the counter is all-ones and still differs, the stable value flips and the counter clears.
  - Press event = stable 0->1. Releases generate no events.
- Cursor movement:
  - Press event moves the cursor: up y-1, down y+1, left x-1, right x+1.
  - Wrap: 0 -> X-1 / Y-1 and X-1 / Y-1 -> 0. Non-power-of-2 X/Y wrap at X-1/Y-1, never at 2^LOG2-1.
  - Priority when several move events coincide: up > down > left > right. One move per cycle; lower-priority events that cycle are dropped.
  - Moves are blocked (events dropped) while cmd_pending=1, so TOGGLE hits the cell selected when it was pressed.
- Auto-repeat:
  - One shared 24-bit timer tracks the highest-priority stable-held cursor button.
  - First repeat move at REPEAT_DELAY cycles after its press event, then every REPEAT_RATE cycles.
  - Timer restarts when the tracked button changes or is released.
- Command capture, on a set or step press event with cmd_pending=0:
  - code = CLEAR if set and step are both stable-high; else TOGGLE on a set event; else STEP.
  - Code latches into the pending register and cmd_pending goes to 1.
  - Press events while cmd_pending=1 are dropped; there is no queue.
- Issue: in a cycle with cmd_pending=1 and ready=1, keys = pending code; cmd_pending clears at that edge. keys = 0 in every other cycle.
- Same-cycle capture and issue is impossible: capture requires cmd_pending=0.
- Latency: raw press at edge 0 -> stable flips at edge 2+2^DEBOUNCE_BITS -> pending at edge 3+2^DEBOUNCE_BITS -> keys valid in the next cycle if ready=1.
- Reset mid-operation: a pending command is discarded and never issued.

Optional Feature:
- LIFE_AUTORUN_EN defined:
  - Adds input btn_run (debounced the same way), output run_active, and parameter RUN_PERIOD (default 24'd12000000).
  - A btn_run press event toggles run_active.
  - While run_active=1, a free counter issues a STEP into the pending register every RUN_PERIOD cycles, only if cmd_pending=0; otherwise that tick is skipped.
  - Manual buttons keep working. A set press also forces run_active to 0.
- LIFE_AUTORUN_EN undefined: btn_run, run_active and the counter are absent; behaviour is exactly as above.

Test Plan (DEBOUNCE_BITS=2, REPEAT_DELAY=20, REPEAT_RATE=5, X=Y=8):
- Reset, then pulse btn_right high for 3 cycles -> no move (bounce rejected). Hold 10 cycles -> cursor_x=1 exactly once.
- Cursor at x=0, press left -> cursor_x=7. Press down 8 times -> cursor_y back to 0.
- Hold btn_up 40 cycles from y=0 -> moves at press, +20, +25, +30, +35 cycles -> cursor_y=3.
- ready=0, press set -> cmd_pending=1, keys stays 0; press right -> cursor unchanged. Raise ready -> keys=1 for one cycle, cmd_pending=0.
- Hold step, then press set while step still stable -> keys=2 first, then keys=3. Press step while a pending TOGGLE waits -> dropped; only keys=1 is issued.
- Assert reset while cmd_pending=1, then ready=1 -> keys stays 0, cursor 0,0.

Source files
------------

// File: rtl/life_keypad.sv
// ---------------------------------------------------------------------------
// life_keypad
//
// Front-end control stage for the life core. Raw board push-buttons are
// synchronised and debounced. Cursor buttons move an edit cursor that wraps
// around the board edges and auto-repeats while held. Set and step buttons
// turn into one-cycle command codes on 'keys', handed to the core through a
// single-entry pending register that drains when the core raises 'ready'.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   btn_up       raw button, cursor row - 1 (wraps)
//   btn_down     raw button, cursor row + 1 (wraps)
//   btn_left     raw button, cursor column - 1 (wraps)
//   btn_right    raw button, cursor column + 1 (wraps)
//   btn_set      raw button, toggle the cell under the cursor
//   btn_step     raw button, advance one generation
//   ready        core accepts a command this cycle
//   keys         command code (0 none, 1 toggle, 2 step, 3 clear), one cycle
//   cursor_x     cursor column
//   cursor_y     cursor row
//   cmd_pending  a command is waiting for ready
//
// Optional feature, enabled by defining LIFE_AUTORUN_EN:
//   btn_run      raw button, toggles run_active
//   run_active   free-running generation stepping is enabled
//   RUN_PERIOD   cycles between automatic STEP commands
// With LIFE_AUTORUN_EN undefined none of the above exist.
// ---------------------------------------------------------------------------
module life_keypad #(
    parameter int          X             = 8,
    parameter int          Y             = 8,
    parameter int          LOG2X         = 3,
    parameter int          LOG2Y         = 3,
    parameter int          DEBOUNCE_BITS = 16,
    parameter logic [23:0] REPEAT_DELAY  = 24'd6000000,
    parameter logic [23:0] REPEAT_RATE   = 24'd1500000
`ifdef LIFE_AUTORUN_EN
    ,
    parameter logic [23:0] RUN_PERIOD    = 24'd12000000
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_set,
    input  logic             btn_step,
`ifdef LIFE_AUTORUN_EN
    input  logic             btn_run,
    output logic             run_active,
`endif
    input  logic             ready,
    output logic [2:0]       keys,
    output logic [LOG2X-1:0] cursor_x,
    output logic [LOG2Y-1:0] cursor_y,
    output logic             cmd_pending
);

    // Command codes shared with the life core.
    localparam logic [2:0] KEY_NONE   = 3'd0;
    localparam logic [2:0] KEY_TOGGLE = 3'd1;
    localparam logic [2:0] KEY_STEP   = 3'd2;
    localparam logic [2:0] KEY_CLEAR  = 3'd3;

    // Bit positions of each button inside the button vectors. The four
    // cursor buttons sit in priority order so index 0 wins.
    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;
    localparam int B_SET   = 4;
    localparam int B_STEP  = 5;
`ifdef LIFE_AUTORUN_EN
    localparam int B_RUN   = 6;
    localparam int NB      = 7;
`else
    localparam int NB      = 6;
`endif

    // Wrap points come from the real board size, not the counter width.
    localparam logic [LOG2X-1:0] X_MAX    = LOG2X'(X - 1);
    localparam logic [LOG2Y-1:0] Y_MAX    = LOG2Y'(Y - 1);
    localparam logic [23:0]      DELAY_M1 = REPEAT_DELAY - 24'd1;
    localparam logic [23:0]      RATE_M1  = REPEAT_RATE - 24'd1;
`ifdef LIFE_AUTORUN_EN
    localparam logic [23:0]      RUN_M1   = RUN_PERIOD - 24'd1;
`endif

    // Auto-repeat waits the long initial delay once, then the short rate.
    typedef enum logic {
        REP_DELAY = 1'b0,
        REP_RATE  = 1'b1
    } rep_phase_t;

    logic [NB-1:0]            raw;
    logic [NB-1:0]            sync1_q;
    logic [NB-1:0]            sync2_q;
    logic [NB-1:0]            stable_q;
    logic [NB-1:0]            stable_d;
    logic [NB-1:0]            prev_q;
    logic [NB-1:0]            press;
    logic [DEBOUNCE_BITS-1:0] cnt_q [NB];
    logic [DEBOUNCE_BITS-1:0] cnt_d [NB];

    logic                     trk_valid_q;
    logic                     trk_valid_d;
    logic [1:0]               trk_idx_q;
    logic [1:0]               trk_idx_d;
    logic [23:0]              rep_tmr_q;
    logic [23:0]              rep_tmr_d;
    rep_phase_t               rep_phase_q;
    rep_phase_t               rep_phase_d;
    logic                     rep_fire;

    logic [3:0]               move_req;
    logic [LOG2X-1:0]         x_q;
    logic [LOG2X-1:0]         x_d;
    logic [LOG2Y-1:0]         y_q;
    logic [LOG2Y-1:0]         y_d;

    logic                     pend_q;
    logic                     pend_d;
    logic [2:0]               code_q;
    logic [2:0]               code_d;

`ifdef LIFE_AUTORUN_EN
    logic                     run_q;
    logic                     run_d;
    logic [23:0]              run_cnt_q;
    logic [23:0]              run_cnt_d;
    logic                     run_tick;

    assign raw = {btn_run, btn_step, btn_set, btn_right, btn_left, btn_down, btn_up};
`else
    assign raw = {btn_step, btn_set, btn_right, btn_left, btn_down, btn_up};
`endif

    // A press is the stable value rising. It is taken from the registered
    // stable state, so the press acts one edge after the stable flip.
    assign press = stable_q & ~prev_q;

    // Debounce: count consecutive samples that disagree with the stable
    // value and flip it only once the counter has saturated.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < NB; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (&cnt_q[i]) begin
                    stable_d[i] = ~stable_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Pick the highest-priority cursor button that is currently held; the
    // repeat timer follows only that one.
    always_comb begin
        trk_valid_d = |stable_q[B_RIGHT:B_UP];
        trk_idx_d   = 2'd0;
        if (stable_q[B_UP]) begin
            trk_idx_d = 2'd0;
        end else if (stable_q[B_DOWN]) begin
            trk_idx_d = 2'd1;
        end else if (stable_q[B_LEFT]) begin
            trk_idx_d = 2'd2;
        end else if (stable_q[B_RIGHT]) begin
            trk_idx_d = 2'd3;
        end
    end

    // The timer restarts whenever the tracked button changes or nothing is
    // held, so it starts from zero on the edge where the press event acts.
    always_comb begin
        rep_tmr_d   = rep_tmr_q;
        rep_phase_d = rep_phase_q;
        rep_fire    = 1'b0;
        if (!trk_valid_d || !trk_valid_q || (trk_idx_d != trk_idx_q)) begin
            rep_tmr_d   = '0;
            rep_phase_d = REP_DELAY;
        end else if (((rep_phase_q == REP_DELAY) && (rep_tmr_q == DELAY_M1)) ||
                     ((rep_phase_q == REP_RATE)  && (rep_tmr_q == RATE_M1))) begin
            rep_fire    = 1'b1;
            rep_tmr_d   = '0;
            rep_phase_d = REP_RATE;
        end else begin
            rep_tmr_d = rep_tmr_q + 24'd1;
        end
    end

    // One move per cycle in fixed priority; everything else that cycle is
    // dropped. Moves freeze while a command waits so a TOGGLE lands on the
    // cell that was selected when it was pressed.
    always_comb begin
        move_req = press[B_RIGHT:B_UP] | (rep_fire ? (4'b0001 << trk_idx_q) : 4'b0000);
        x_d      = x_q;
        y_d      = y_q;
        if (!pend_q) begin
            if (move_req[B_UP]) begin
                y_d = (y_q == '0) ? Y_MAX : (y_q - 1'b1);
            end else if (move_req[B_DOWN]) begin
                y_d = (y_q == Y_MAX) ? '0 : (y_q + 1'b1);
            end else if (move_req[B_LEFT]) begin
                x_d = (x_q == '0) ? X_MAX : (x_q - 1'b1);
            end else if (move_req[B_RIGHT]) begin
                x_d = (x_q == X_MAX) ? '0 : (x_q + 1'b1);
            end
        end
    end

`ifdef LIFE_AUTORUN_EN
    // Run mode: toggled by its own button, cancelled by a set press, and
    // ticking a free counter only while active.
    always_comb begin
        run_d     = run_q;
        run_cnt_d = run_cnt_q;
        run_tick  = 1'b0;
        if (press[B_SET]) begin
            run_d = 1'b0;
        end else if (press[B_RUN]) begin
            run_d = ~run_q;
        end
        if (!run_q) begin
            run_cnt_d = '0;
        end else if (run_cnt_q == RUN_M1) begin
            run_tick  = 1'b1;
            run_cnt_d = '0;
        end else begin
            run_cnt_d = run_cnt_q + 24'd1;
        end
    end
`endif

    // Single-entry command register. While it is full every new request is
    // dropped; an automatic step tick also loses to a manual press.
    always_comb begin
        pend_d = pend_q;
        code_d = code_q;
        if (pend_q) begin
            if (ready) begin
                pend_d = 1'b0;
            end
        end else if (press[B_SET] || press[B_STEP]) begin
            pend_d = 1'b1;
            if (stable_q[B_SET] && stable_q[B_STEP]) begin
                code_d = KEY_CLEAR;
            end else if (press[B_SET]) begin
                code_d = KEY_TOGGLE;
            end else begin
                code_d = KEY_STEP;
            end
        end
`ifdef LIFE_AUTORUN_EN
        else if (run_tick) begin
            pend_d = 1'b1;
            code_d = KEY_STEP;
        end
`endif
    end

    // All state lives here; reset clears synchronisers, debounce state,
    // repeat tracking, cursor and any waiting command.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            prev_q      <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
            trk_valid_q <= 1'b0;
            trk_idx_q   <= 2'd0;
            rep_tmr_q   <= '0;
            rep_phase_q <= REP_DELAY;
            x_q         <= '0;
            y_q         <= '0;
            pend_q      <= 1'b0;
            code_q      <= KEY_NONE;
`ifdef LIFE_AUTORUN_EN
            run_q       <= 1'b0;
            run_cnt_q   <= '0;
`endif
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            prev_q      <= stable_q;
            cnt_q       <= cnt_d;
            trk_valid_q <= trk_valid_d;
            trk_idx_q   <= trk_idx_d;
            rep_tmr_q   <= rep_tmr_d;
            rep_phase_q <= rep_phase_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pend_q      <= pend_d;
            code_q      <= code_d;
`ifdef LIFE_AUTORUN_EN
            run_q       <= run_d;
            run_cnt_q   <= run_cnt_d;
`endif
        end
    end

    // keys is the pending code gated by ready, so it is valid exactly in the
    // cycle where the core takes it and zero otherwise.
    assign keys        = (pend_q && ready) ? code_q : KEY_NONE;
    assign cursor_x    = x_q;
    assign cursor_y    = y_q;
    assign cmd_pending = pend_q;
`ifdef LIFE_AUTORUN_EN
    assign run_active  = run_q;
`endif

endmodule

// File: tb/tb_life_keypad.sv
// ---------------------------------------------------------------------------
// tb_life_keypad
//
// Self-checking bench for life_keypad with a short debounce (4 samples),
// repeat delay 20 and repeat rate 5 on an 8x8 board. Expected cursor
// positions and key codes are queued when stimulus is applied; a negedge
// monitor pops them whenever the cursor moves or keys is non-zero.
// ---------------------------------------------------------------------------
module tb_life_keypad;

    localparam int X = 8;
    localparam int Y = 8;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
    } pos_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] btn   = 6'd0;
    logic       ready = 1'b0;
    logic [2:0] keys;
    logic [2:0] cursor_x;
    logic [2:0] cursor_y;
    logic       cmd_pending;

    pos_t       exp_cur[$];
    logic [2:0] exp_key[$];
    int         move_times[$];

    int         errors  = 0;
    int         checks  = 0;
    int         cycle   = 0;
    bit         mon_en  = 1'b0;
    logic [2:0] last_x  = 3'd0;
    logic [2:0] last_y  = 3'd0;
    int         model_x = 0;
    int         model_y = 0;
    pos_t       mon_ep;
    logic [2:0] mon_ek;

    // 10 ns clock with a free cycle counter used to time cursor moves.
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    life_keypad #(
        .X            (8),
        .Y            (8),
        .LOG2X        (3),
        .LOG2Y        (3),
        .DEBOUNCE_BITS(2),
        .REPEAT_DELAY (24'd20),
        .REPEAT_RATE  (24'd5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_up     (btn[0]),
        .btn_down   (btn[1]),
        .btn_left   (btn[2]),
        .btn_right  (btn[3]),
        .btn_set    (btn[4]),
        .btn_step   (btn[5]),
        .ready      (ready),
        .keys       (keys),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .cmd_pending(cmd_pending)
    );

    // Scoreboard monitor: any non-zero keys value and any cursor change must
    // match the next queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (keys !== 3'd0) begin
                checks++;
                if (exp_key.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_keys: got %0d, required 0", keys);
                end else begin
                    mon_ek = exp_key.pop_front();
                    if (keys !== mon_ek) begin
                        errors++;
                        $display("[TB] FAIL keys_code: got %0d, required %0d", keys, mon_ek);
                    end
                end
            end
            if (cursor_x !== last_x || cursor_y !== last_y) begin
                checks++;
                move_times.push_back(cycle);
                if (exp_cur.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_move: got (%0d,%0d), required (%0d,%0d)",
                             cursor_x, cursor_y, last_x, last_y);
                end else begin
                    mon_ep = exp_cur.pop_front();
                    if (cursor_x !== mon_ep.x || cursor_y !== mon_ep.y) begin
                        errors++;
                        $display("[TB] FAIL cursor_pos: got (%0d,%0d), required (%0d,%0d)",
                                 cursor_x, cursor_y, mon_ep.x, mon_ep.y);
                    end
                end
                last_x = cursor_x;
                last_y = cursor_y;
            end
        end
    end

    // Hard stop in case something wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Update the cursor model for one move and queue the expected position.
    task automatic expect_move(input int dir);
        case (dir)
            0: model_y = (model_y + Y - 1) % Y;
            1: model_y = (model_y + 1) % Y;
            2: model_x = (model_x + X - 1) % X;
            default: model_x = (model_x + 1) % X;
        endcase
        exp_cur.push_back('{x: 3'(model_x), y: 3'(model_y)});
    endtask

    task automatic press(input int idx, input int hold);
        btn[idx] = 1'b1;
        tick(hold);
        btn[idx] = 1'b0;
        tick(10);
    endtask

    task automatic applyStimulus_ready_pulse(input int n);
        tick(1);
        ready = 1'b1;
        tick(n);
        ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        @(negedge clk);
        checks++;
        if (keys !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_keys: got %0d, required 0", keys);
        end
        checks++;
        if (cursor_x !== 3'd0 || cursor_y !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_cursor: got (%0d,%0d), required (0,0)", cursor_x, cursor_y);
        end
        checks++;
        if (cmd_pending !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_pending: got %0b, required 0", cmd_pending);
        end
        tick(1);
        reset  = 1'b0;
        last_x = 3'd0;
        last_y = 3'd0;
        mon_en = 1'b1;
        tick(2);
    endtask

    task automatic test_debounce;
        btn[3] = 1'b1;
        tick(3);
        btn[3] = 1'b0;
        tick(12);
        @(negedge clk);
        checks++;
        if (cursor_x !== 3'd0) begin
            errors++;
            $display("[TB] FAIL bounce_reject: got x=%0d, required x=0", cursor_x);
        end
        expect_move(3);
        press(3, 10);
        @(negedge clk);
        checks++;
        if (cursor_x !== 3'd1) begin
            errors++;
            $display("[TB] FAIL debounced_right: got x=%0d, required x=1", cursor_x);
        end
    endtask

    task automatic test_wrap;
        expect_move(2);
        press(2, 10);
        expect_move(2);
        press(2, 10);
        @(negedge clk);
        checks++;
        if (cursor_x !== 3'd7) begin
            errors++;
            $display("[TB] FAIL wrap_left: got x=%0d, required x=7", cursor_x);
        end
        for (int i = 0; i < 8; i++) begin
            expect_move(1);
            press(1, 10);
        end
        @(negedge clk);
        checks++;
        if (cursor_y !== 3'd0) begin
            errors++;
            $display("[TB] FAIL wrap_down: got y=%0d, required y=0", cursor_y);
        end
    endtask

    task automatic test_repeat;
        int start;
        int offs[5];
        offs = '{7, 27, 32, 37, 42};
        tick(1);
        move_times.delete();
        start = cycle;
        for (int i = 0; i < 5; i++) expect_move(0);
        btn[0] = 1'b1;
        tick(40);
        btn[0] = 1'b0;
        tick(12);
        @(negedge clk);
        checks++;
        if (cursor_y !== 3'd3) begin
            errors++;
            $display("[TB] FAIL repeat_final_y: got y=%0d, required y=3", cursor_y);
        end
        checks++;
        if (move_times.size() != 5) begin
            errors++;
            $display("[TB] FAIL repeat_count: got %0d moves, required 5", move_times.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (move_times[i] - start != offs[i]) begin
                    errors++;
                    $display("[TB] FAIL repeat_time%0d: got offset %0d, required %0d",
                             i, move_times[i] - start, offs[i]);
                end
            end
        end
    endtask

    task automatic test_toggle;
        press(4, 10);
        @(negedge clk);
        checks++;
        if (cmd_pending !== 1'b1 || keys !== 3'd0) begin
            errors++;
            $display("[TB] FAIL toggle_wait: got pending=%0b keys=%0d, required pending=1 keys=0",
                     cmd_pending, keys);
        end
        press(3, 10);
        @(negedge clk);
        checks++;
        if (cursor_x !== 3'(model_x) || cursor_y !== 3'(model_y)) begin
            errors++;
            $display("[TB] FAIL move_blocked: got (%0d,%0d), required (%0d,%0d)",
                     cursor_x, cursor_y, model_x, model_y);
        end
        exp_key.push_back(3'd1);
        tick(1);
        ready = 1'b1;
        @(negedge clk);
        checks++;
        if (keys !== 3'd1) begin
            errors++;
            $display("[TB] FAIL toggle_issue: got keys=%0d, required 1", keys);
        end
        tick(1);
        @(negedge clk);
        checks++;
        if (cmd_pending !== 1'b0 || keys !== 3'd0) begin
            errors++;
            $display("[TB] FAIL toggle_drained: got pending=%0b keys=%0d, required 0 and 0",
                     cmd_pending, keys);
        end
        tick(3);
        ready = 1'b0;
    endtask

    task automatic test_clear;
        btn[5] = 1'b1;
        tick(10);
        @(negedge clk);
        checks++;
        if (cmd_pending !== 1'b1) begin
            errors++;
            $display("[TB] FAIL step_pending: got %0b, required 1", cmd_pending);
        end
        exp_key.push_back(3'd2);
        applyStimulus_ready_pulse(1);
        press(4, 10);
        exp_key.push_back(3'd3);
        applyStimulus_ready_pulse(1);
        btn[5] = 1'b0;
        tick(10);
        @(negedge clk);
        checks++;
        if (cmd_pending !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_drained: got %0b, required 0", cmd_pending);
        end
    endtask

    task automatic test_dropped;
        press(4, 10);
        press(5, 10);
        @(negedge clk);
        checks++;
        if (cmd_pending !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drop_pending: got %0b, required 1", cmd_pending);
        end
        exp_key.push_back(3'd1);
        applyStimulus_ready_pulse(6);
        @(negedge clk);
        checks++;
        if (cmd_pending !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_drained: got %0b, required 0", cmd_pending);
        end
    endtask

    task automatic test_reset_mid;
        press(4, 10);
        @(negedge clk);
        checks++;
        if (cmd_pending !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_pending: got %0b, required 1", cmd_pending);
        end
        if (model_x != 0 || model_y != 0) begin
            model_x = 0;
            model_y = 0;
            exp_cur.push_back('{x: 3'd0, y: 3'd0});
        end
        tick(1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        ready = 1'b1;
        tick(6);
        @(negedge clk);
        checks++;
        if (cmd_pending !== 1'b0 || cursor_x !== 3'd0 || cursor_y !== 3'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got pending=%0b (%0d,%0d), required pending=0 (0,0)",
                     cmd_pending, cursor_x, cursor_y);
        end
        tick(1);
        ready = 1'b0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_wrap();
        test_repeat();
        test_toggle();
        test_clear();
        test_dropped();
        test_reset_mid();
        @(negedge clk);
        checks++;
        if (exp_key.size() != 0) begin
            errors++;
            $display("[TB] FAIL keys_outstanding: got %0d left, required 0", exp_key.size());
        end
        checks++;
        if (exp_cur.size() != 0) begin
            errors++;
            $display("[TB] FAIL moves_outstanding: got %0d left, required 0", exp_cur.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
